// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler.
// Holds the FSM state encoding, the byte width and the default
// FIFO address width and busy-handshake timeout.
package uart_pkg;

  localparam int BYTE_W      = 8;
  localparam int DEF_AW      = 3;
  localparam int DEF_BUSY_TO = 16;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_WAIT_HI = 3'd3;
  localparam logic [2:0] ST_WAIT_LO = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    LOAD    = ST_LOAD,
    START   = ST_START,
    WAIT_HI = ST_WAIT_HI,
    WAIT_LO = ST_WAIT_LO,
    DONE    = ST_DONE
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Circular byte FIFO of depth 2**AW.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/wr_data_i
// write side; pop_i/rd_data_o read side (rd_data_o shows the head);
// flush_i synchronous clear with priority over push/pop; count_o, full_o,
// empty_o occupancy status. Pushes while full and pops while empty are ignored.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] wr_data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [BYTE_W-1:0] rd_data_o,
  output logic [AW:0]       count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              push_ok_s, pop_ok_s;

  assign full_o    = (count_q == DEPTH_C);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A push while full is dropped even if a pop frees a slot this cycle.
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;

  // Next-state pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy guards every read.
  always_ff @(posedge clk_i) begin
    if (push_ok_s && !flush_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Transmit scheduler between the bus-facing TX FIFO and the serial transmitter.
// Ports: clk, reset (async active-low); enable run control; wr_en/wr_data
// byte push; flush FIFO clear; irq_en drain interrupt enable; clr_flags clears
// sticky flags; tx_busy transmitter handshake in. Outputs: tx_start strobe and
// tx_data byte to the transmitter; count/full/empty FIFO status; sticky
// ovf (push while full), tmo (busy never rose) and irq (drain complete).
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int BUSY_TO = DEF_BUSY_TO
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              flush,
  input  logic              irq_en,
  input  logic              clr_flags,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              tmo,
  output logic              irq
);

  localparam int          TW      = $clog2(BUSY_TO + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TO - 1);

  tx_state_e         state_q, state_d;
  logic [TW-1:0]     cnt_q, cnt_d, cnt_inc_s;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              ovf_q, ovf_d, tmo_q, tmo_d, irq_q, irq_d;
  logic              pop_s, tmo_set_s, irq_set_s, ovf_set_s;
  logic [BYTE_W-1:0] fifo_rd_s;
  logic              fifo_full_s, fifo_empty_s;

  sync_fifo #(.AW(AW)) u_fifo (
    .clk_i     (clk),
    .rst_ni    (reset),
    .push_i    (wr_en),
    .wr_data_i (wr_data),
    .pop_i     (pop_s),
    .flush_i   (flush),
    .rd_data_o (fifo_rd_s),
    .count_o   (count),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s)
  );

  assign full      = fifo_full_s;
  assign empty     = fifo_empty_s;
  assign cnt_inc_s = cnt_q + TW'(1);
  assign ovf_set_s = wr_en & fifo_full_s;

  // Scheduler next state, byte latch, timeout counter and flag set requests.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    pop_s     = 1'b0;
    tmo_set_s = 1'b0;
    irq_set_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !fifo_empty_s) begin
          state_d   = LOAD;
          pop_s     = 1'b1;
          tx_data_d = fifo_rd_s;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD:  state_d = START;
      START: begin
        cnt_d   = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        // A busy level left over from a previous byte also counts as the rise.
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (cnt_inc_s == TO_LAST) begin
          tmo_set_s = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          state_d = DONE;
        end else begin
          state_d = WAIT_LO;
        end
      end
      DONE: begin
        if (fifo_empty_s && irq_en) begin
          irq_set_s = 1'b1;
        end else begin
          irq_set_s = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    tx_start_d = (state_d == START);
  end

  // Sticky flags: a set request in the same cycle as clr_flags wins.
  always_comb begin
    ovf_d = ovf_set_s | (ovf_q & ~clr_flags);
    tmo_d = tmo_set_s | (tmo_q & ~clr_flags);
    irq_d = irq_set_s | (irq_q & ~clr_flags);
  end

  // State, datapath and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
      irq_q      <= irq_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign ovf      = ovf_q;
  assign tmo      = tmo_q;
  assign irq      = irq_q;

endmodule
